rd_ptr_ctrl: RTL and testbench

Parametrised read-side controller for the async FIFO, replacing the fixed single-mode read control. It runs entirely in the read clock domain and synchronises the incoming Gray write pointer itself. It maintains binary and Gray read pointers and drives the RAM read port. It produces empty, almost-empty, occupancy and underflow status, and can optionally run in first-word-fall-through mode.

---
 rtl/rd_ptr_ctrl_if.sv | 31 +++
 rtl/rd_ptr_ctrl.sv | 94 +++++++++
 tb/tb_rd_ptr_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rd_ptr_ctrl_if.sv
// rtl/rd_ptr_ctrl_if.sv - read-side FIFO control bundle; rvalid_o exists only with RD_PTR_CTRL_FWFT_EN
interface rd_ptr_ctrl_if #(parameter int AW = 5);
  logic          rd_req_i;
  logic [AW:0]   wgray_i;
  logic          ren_o;
  logic [AW-1:0] raddr_o;
  logic [AW:0]   rgray_o;
  logic          empty_o;
  logic          aempty_o;
  logic [AW:0]   rlevel_o;
  logic          underflow_o;
`ifdef RD_PTR_CTRL_FWFT_EN
  logic          rvalid_o;
`endif

  modport slave (
    input  rd_req_i, wgray_i,
    output ren_o, raddr_o, rgray_o, empty_o, aempty_o, rlevel_o, underflow_o
`ifdef RD_PTR_CTRL_FWFT_EN
    , output rvalid_o
`endif
  );

  modport master (
    output rd_req_i, wgray_i,
    input  ren_o, raddr_o, rgray_o, empty_o, aempty_o, rlevel_o, underflow_o
`ifdef RD_PTR_CTRL_FWFT_EN
    , input rvalid_o
`endif
  );
endinterface

// File: rtl/rd_ptr_ctrl.sv
// rtl/rd_ptr_ctrl.sv - async FIFO read pointer/status controller; optional FWFT via RD_PTR_CTRL_FWFT_EN
module rd_ptr_ctrl #(
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 4
) (
  input  logic         rclk,
  input  logic         rst,
  rd_ptr_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AE_T = (AW+1)'(AE_THRESH);

  logic [AW:0] sync_q [SYNC_STAGES];
  logic [AW:0] wgray_s;
  logic [AW:0] wbin_s;
  logic [AW:0] rbin;
  logic [AW:0] rbin_next;
  logic [AW:0] rgray_q;
  logic [AW:0] level_q;
  logic [AW:0] level_next;
  logic        empty_q;
  logic        aempty_q;
  logic        underflow_q;
  logic        pop;
`ifdef RD_PTR_CTRL_FWFT_EN
  logic        rvalid_q;
`endif

  always_ff @(posedge rclk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.wgray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wgray_s = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= AW; i++) wbin_s[i] = ^(wgray_s >> i);
  end

`ifdef RD_PTR_CTRL_FWFT_EN
  assign pop = ~empty_q & (~rvalid_q | bus.rd_req_i);
`else
  assign pop = bus.rd_req_i & ~empty_q;
`endif

  assign rbin_next  = rbin + {{AW{1'b0}}, pop};
  assign level_next = wbin_s - rbin_next;

  always_ff @(posedge rclk) begin
    if (rst) begin
      rbin        <= '0;
      rgray_q     <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      rgray_q     <= rbin_next ^ (rbin_next >> 1);
      level_q     <= level_next;
      empty_q     <= ((rbin_next ^ (rbin_next >> 1)) == wgray_s);
      aempty_q    <= (level_next <= AE_T);
`ifdef RD_PTR_CTRL_FWFT_EN
      underflow_q <= bus.rd_req_i & ~rvalid_q;
`else
      underflow_q <= bus.rd_req_i & empty_q;
`endif
    end
  end

`ifdef RD_PTR_CTRL_FWFT_EN
  // The held word stays valid until the consumer accepts it.
  always_ff @(posedge rclk) begin
    if (rst) rvalid_q <= 1'b0;
    else     rvalid_q <= pop | (rvalid_q & ~bus.rd_req_i);
  end
  assign bus.rvalid_o = rvalid_q;
`endif

  assign bus.ren_o       = pop;
  assign bus.raddr_o     = rbin[AW-1:0];
  assign bus.rgray_o     = rgray_q;
  assign bus.empty_o     = empty_q;
  assign bus.aempty_o    = aempty_q;
  assign bus.rlevel_o    = level_q;
  assign bus.underflow_o = underflow_q;
endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// tb/tb_rd_ptr_ctrl.sv - randomized bench for rd_ptr_ctrl against a count-based reference model
module tb_rd_ptr_ctrl;
  localparam int DEPTH = 32;
  localparam int SYNC  = 2;
  localparam int AE    = 4;
  localparam int AW    = 5;
  localparam int MAXC  = 4096;

  logic rclk = 1'b0;
  logic rst  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  rd_ptr_ctrl_if #(.AW(AW)) bus ();

  rd_ptr_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .AE_THRESH(AE)) dut (
    .rclk (rclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 rclk = ~rclk;

  // Reference state: total writes issued, total words fetched, and the
  // write count the read side can see (delayed by the synchroniser).
  int wcnt = 0;
  int rd_cnt = 0;
  int wlog [MAXC];
  int cyc = 0;
  int last_rst = 0;
  bit chk_en = 0;
  bit e_empty = 1, e_aempty = 1, e_uf = 0, e_rvalid = 0;
  int e_level = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic cycle(input bit req, input bit wr, input bit r);
    bit pop_e;
    int seen;
    @(negedge rclk);
    if (chk_en) begin
      check("empty", 32'(bus.empty_o), 32'(e_empty));
      check("aempty", 32'(bus.aempty_o), 32'(e_aempty));
      check("level", 32'(bus.rlevel_o), 32'(e_level));
      check("underflow", 32'(bus.underflow_o), 32'(e_uf));
      check("rgray", 32'(bus.rgray_o), 32'(gray(rd_cnt)));
`ifdef RD_PTR_CTRL_FWFT_EN
      check("rvalid", 32'(bus.rvalid_o), 32'(e_rvalid));
`endif
    end
    if (r) wcnt = 0;
    else if (wr && (wcnt - rd_cnt) < DEPTH) wcnt++;
    rst = r;
    bus.rd_req_i = req;
    bus.wgray_i = gray(wcnt);
    wlog[cyc] = r ? 0 : wcnt;
    #1;
`ifdef RD_PTR_CTRL_FWFT_EN
    pop_e = !e_empty && (!e_rvalid || req);
`else
    pop_e = req && !e_empty;
`endif
    if (!r && chk_en) begin
      check("ren", 32'(bus.ren_o), 32'(pop_e));
      if (pop_e) check("raddr", 32'(bus.raddr_o), 32'(rd_cnt % DEPTH));
    end
    if (r) begin
      rd_cnt = 0; e_empty = 1; e_aempty = 1; e_level = 0; e_uf = 0; e_rvalid = 0;
      last_rst = cyc;
    end else begin
      seen = (cyc - SYNC > last_rst) ? wlog[cyc - SYNC] : 0;
`ifdef RD_PTR_CTRL_FWFT_EN
      e_uf = req && !e_rvalid;
      e_rvalid = pop_e || (e_rvalid && !req);
`else
      e_uf = req && e_empty;
`endif
      if (pop_e) rd_cnt++;
      e_level = seen - rd_cnt;
      e_empty = (e_level == 0);
      e_aempty = (e_level <= AE);
    end
    chk_en = 1;
    cyc++;
  endtask

  initial begin
    int wp, rp;
    bus.rd_req_i = 1'b0;
    bus.wgray_i = '0;
    repeat (3) cycle(0, 0, 1);
    // Reads against an empty FIFO.
    repeat (3) cycle(1, 0, 0);
    // Three writes then drain them.
    repeat (3) cycle(0, 1, 0);
    repeat (SYNC + 2) cycle(0, 0, 0);
    repeat (4) cycle(1, 0, 0);
    // Randomised traffic with varied write/read densities; wraps the pointers.
    for (int ph = 0; ph < 8; ph++) begin
      wp = $urandom_range(10, 100);
      rp = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++)
        cycle($urandom_range(1, 100) <= rp, $urandom_range(1, 100) <= wp, 0);
    end
    // Drain, then fill to full with no reads.
    repeat (60) cycle(1, 0, 0);
    repeat (40) cycle(0, 1, 0);
    repeat (SYNC + 2) cycle(0, 0, 0);
    @(negedge rclk);
`ifdef RD_PTR_CTRL_FWFT_EN
    check("full_level", 32'(bus.rlevel_o), 32'(DEPTH - 1));
`else
    check("full_level", 32'(bus.rlevel_o), 32'(DEPTH));
    check("full_aempty", 32'(bus.aempty_o), 32'(0));
`endif
    // Mid-stream reset, then resume.
    cycle(1, 1, 1);
    repeat (4) cycle(1, 1, 0);
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    repeat (60) cycle(1, 0, 0);
    cycle(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
